npu_buf_ram: RTL



---
 rtl/npu_buf_ram.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/npu_buf_ram.sv
// -----------------------------------------------------------------------------
// npu_buf_ram
// Simple-dual-port buffer RAM for the NPU datapath: one write port fed by the
// host/DMA loader, one independent read port feeding the compute pipeline, and
// a clear engine that sweeps zeros through the whole array.
//
// Parameters
//   DATA_W  : word width in bits
//   ADDR_W  : address width, depth = 2**ADDR_W words
//   OUT_REG : 0 -> 1-cycle read latency, 1 -> extra output register (2 cycles)
//   BYPASS  : 1 -> same-address read/write returns new data (write-first)
//             0 -> returns the previous contents (read-first)
//
// Ports
//   clock    : sole clock, rising edge
//   reset    : synchronous, active-high
//   wr_en    : write strobe        wr_addr / wr_data : write address / data
//   rd_en    : read strobe         rd_addr           : read address
//   rd_data  : read data, holds between reads
//   rd_valid : one-cycle pulse marking a new rd_data
//   clear    : one-cycle request to zero the entire array
//   busy     : high while the clear engine runs
// -----------------------------------------------------------------------------
module npu_buf_ram #(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 16,
    parameter int OUT_REG = 0,
    parameter int BYPASS  = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              clear,
    output logic              busy
);

    localparam int              DEPTH   = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] CNT_MAX = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] CNT_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam bit              BYP_EN  = (BYPASS != 0);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t              state_q;
    logic [ADDR_W-1:0]   cnt_q;
    logic                busy_q;

    logic [DATA_W-1:0]   mem_q [DEPTH];

    logic                mem_we_s;
    logic [ADDR_W-1:0]   mem_waddr_s;
    logic [DATA_W-1:0]   mem_wdata_s;
    logic                rd_accept_s;

    logic [DATA_W-1:0]   ram_q;
    logic                fwd_hit_q;
    logic [DATA_W-1:0]   fwd_data_q;
    logic                s1_valid_q;
    logic [DATA_W-1:0]   s1_data_s;

    // Host accesses are only taken in IDLE; a clear request in IDLE still lets
    // that cycle's read and write through.
    assign rd_accept_s = (state_q == ST_IDLE) && rd_en;

    // Select the single write port source: host write in IDLE, zero sweep in CLEAR.
    // Writes are suppressed under reset so a reset mid-sweep stops cleanly.
    always_comb begin
        mem_we_s    = 1'b0;
        mem_waddr_s = wr_addr;
        mem_wdata_s = wr_data;
        if (reset) begin
            mem_we_s = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    mem_we_s    = wr_en;
                    mem_waddr_s = wr_addr;
                    mem_wdata_s = wr_data;
                end
                ST_CLEAR: begin
                    mem_we_s    = 1'b1;
                    mem_waddr_s = cnt_q;
                    mem_wdata_s = {DATA_W{1'b0}};
                end
                default: begin
                    mem_we_s    = 1'b0;
                    mem_waddr_s = wr_addr;
                    mem_wdata_s = wr_data;
                end
            endcase
        end
    end

    // Clear-engine FSM: counter sweeps 0..2**ADDR_W-1 once, busy is registered.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= {ADDR_W{1'b0}};
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    cnt_q <= {ADDR_W{1'b0}};
                    if (clear) begin
                        state_q <= ST_CLEAR;
                        busy_q  <= 1'b1;
                    end else begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                ST_CLEAR: begin
                    // Explicit terminal compare: the sweep never wraps into a second pass.
                    if (cnt_q == CNT_MAX) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        cnt_q   <= {ADDR_W{1'b0}};
                    end else begin
                        state_q <= ST_CLEAR;
                        busy_q  <= 1'b1;
                        cnt_q   <= cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    cnt_q   <= {ADDR_W{1'b0}};
                end
            endcase
        end
    end

    assign busy = busy_q;

    // Array write port (no reset on the storage itself).
    always_ff @(posedge clock) begin
        if (mem_we_s) begin
            mem_q[mem_waddr_s] <= mem_wdata_s;
        end
    end

    // Synchronous RAM read; only reloaded on an accepted read so the value holds.
    always_ff @(posedge clock) begin
        if (reset) begin
            ram_q <= {DATA_W{1'b0}};
        end else if (rd_accept_s) begin
            ram_q <= mem_q[rd_addr];
        end
    end

    // Forwarding register: captures same-cycle write data on an address match so
    // write-first behaviour never relies on the RAM's read-during-write mode.
    always_ff @(posedge clock) begin
        if (reset) begin
            fwd_hit_q  <= 1'b0;
            fwd_data_q <= {DATA_W{1'b0}};
        end else if (rd_accept_s) begin
            fwd_hit_q  <= BYP_EN && wr_en && (wr_addr == rd_addr);
            fwd_data_q <= wr_data;
        end
    end

    // First-stage valid; reset flushes any read in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
        end else begin
            s1_valid_q <= rd_accept_s;
        end
    end

    assign s1_data_s = fwd_hit_q ? fwd_data_q : ram_q;

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [DATA_W-1:0] out_data_q;
            logic              out_valid_q;

            // Optional output register stage, data held when no new result.
            always_ff @(posedge clock) begin
                if (reset) begin
                    out_data_q  <= {DATA_W{1'b0}};
                    out_valid_q <= 1'b0;
                end else begin
                    out_valid_q <= s1_valid_q;
                    if (s1_valid_q) begin
                        out_data_q <= s1_data_s;
                    end
                end
            end

            assign rd_data  = out_data_q;
            assign rd_valid = out_valid_q;
        end else begin : g_no_out_reg
            assign rd_data  = s1_data_s;
            assign rd_valid = s1_valid_q;
        end
    endgenerate

endmodule
